// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI boot-flash Wishbone reader.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        ACK,
        ERR
    } state_e;

    localparam int         FRAME_BITS     = 64;
    localparam int         DATA_BITS      = 32;
    localparam logic [7:0] DEFAULT_OPCODE = 8'h03;

    // Flash streams bytes in address order; the bus word is little-endian.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 frame engine: chip-select setup phase, then 64 bits out MSB first
// while the last 32 bits in are collected.
module spi_flash_shifter
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [FRAME_BITS-1:0] tx_word_i,
    input  logic                  miso_i,
    output logic                  setup_done_o,
    output logic                  done_o,
    output logic [DATA_BITS-1:0]  rx_word_o,
    output logic                  sclk_o,
    output logic                  mosi_o
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]       LAST_BIT   = 7'(FRAME_BITS - 1);
    localparam logic [6:0]       FIRST_RX   = 7'(FRAME_BITS - DATA_BITS);

    logic                  busy_q, busy_d;
    logic                  setup_q, setup_d;
    logic                  sclk_q, sclk_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [6:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_BITS-1:0]  rx_q, rx_d;
    logic                  tick;

    assign tick      = (div_q == '0);
    assign sclk_o    = sclk_q;
    assign mosi_o    = tx_q[FRAME_BITS-1];
    assign rx_word_o = rx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            busy_q  <= 1'b0;
            setup_q <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            setup_q <= setup_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    // Every phase (setup, low, high) lasts CLK_DIV cycles; the divider reloads on each change.
    always_comb begin
        busy_d       = busy_q;
        setup_d      = setup_q;
        sclk_d       = sclk_q;
        div_d        = div_q;
        bit_d        = bit_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        setup_done_o = 1'b0;
        done_o       = 1'b0;

        if (abort_i) begin
            busy_d  = 1'b0;
            setup_d = 1'b0;
            sclk_d  = 1'b0;
            div_d   = DIV_RELOAD;
            bit_d   = '0;
            tx_d    = '0;
        end else if (start_i) begin
            busy_d  = 1'b1;
            setup_d = 1'b1;
            sclk_d  = 1'b0;
            div_d   = DIV_RELOAD;
            bit_d   = '0;
            tx_d    = tx_word_i;
            rx_d    = '0;
        end else if (busy_q) begin
            if (!tick) begin
                div_d = div_q - DIV_W'(1);
            end else begin
                div_d = DIV_RELOAD;
                if (setup_q) begin
                    setup_d      = 1'b0;
                    setup_done_o = 1'b1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    if (bit_q >= FIRST_RX) begin
                        rx_d = {rx_q[DATA_BITS-2:0], miso_i};
                    end
                end else begin
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_q == LAST_BIT) begin
                        busy_d = 1'b0;
                        done_o = 1'b1;
                    end else begin
                        bit_d = bit_q + 7'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_wb_reader.sv
// Read-only Wishbone classic slave mapping the SPI boot flash; each read is one
// READ frame returning a little-endian word, writes are answered with err.
module spi_flash_wb_reader
    import spi_flash_pkg::*;
#(
    parameter int         CLK_DIV     = 2,
    parameter int         FLASH_AW    = 24,
    parameter logic [7:0] READ_OPCODE = DEFAULT_OPCODE
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        spi_cs_n_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    state_e                state_q, state_d;
    logic                  cs_n_q, cs_n_d;
    logic [31:0]           dat_q, dat_d;
    logic                  start, abort, setup_done, shift_done;
    logic [DATA_BITS-1:0]  rx_word;
    logic [FRAME_BITS-1:0] tx_word;
    logic                  unused_inputs;

    assign tx_word       = {READ_OPCODE, wb_adr_i[FLASH_AW-1:2], 2'b00, 32'h0};
    assign unused_inputs = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:FLASH_AW], wb_adr_i[1:0]};

    spi_flash_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start),
        .abort_i      (abort),
        .tx_word_i    (tx_word),
        .miso_i       (spi_miso_i),
        .setup_done_o (setup_done),
        .done_o       (shift_done),
        .rx_word_o    (rx_word),
        .sclk_o       (spi_sclk_o),
        .mosi_o       (spi_mosi_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            dat_q   <= dat_d;
        end
    end

    // A master dropping cyc mid-frame abandons the transfer without any response.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        start   = 1'b0;
        abort   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (wb_we_i) begin
                        state_d = ERR;
                    end else begin
                        state_d = CS_SETUP;
                        start   = 1'b1;
                    end
                end
            end
            CS_SETUP: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (setup_done) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (shift_done) begin
                    state_d = CS_HOLD;
                end
            end
            CS_HOLD: begin
                state_d = ACK;
                dat_d   = swap_bytes(rx_word);
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
    end

    assign spi_cs_n_o = cs_n_q;
    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = (state_q == ACK) && wb_cyc_i;
    assign wb_err_o   = (state_q == ERR) && wb_cyc_i;

endmodule

// File: tb/tb_spi_flash_wb_reader.sv
// Directed bench for spi_flash_wb_reader with a behavioural SPI READ flash model.
module tb_spi_flash_wb_reader;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        spi_cs_n_o;
    logic        spi_sclk_o;
    logic        spi_mosi_o;
    logic        spi_miso_i = 1'b0;

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0]  mem [0:1023];
    int          fl_bits = 0;
    logic [31:0] fl_cmd = '0;
    logic [31:0] fl_data = '0;
    logic [31:0] lastCmd = '0;
    int          csHighRun = 0;
    int          lastGap = 0;

    spi_flash_wb_reader #(
        .CLK_DIV     (2),
        .FLASH_AW    (24),
        .READ_OPCODE (8'h03)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .spi_cs_n_o (spi_cs_n_o),
        .spi_sclk_o (spi_sclk_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i)
    );

    always #5 clk_i = ~clk_i;

    // Flash model: command bits captured on SCLK rise, data driven after SCLK fall.
    always @(negedge spi_cs_n_o or posedge spi_sclk_o) begin
        if (spi_sclk_o) begin
            if (!spi_cs_n_o) begin
                if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], spi_mosi_o};
                fl_bits = fl_bits + 1;
                if (fl_bits == 32) begin
                    lastCmd = fl_cmd;
                    fl_data = {mem[fl_cmd[9:0]], mem[fl_cmd[9:0] + 10'd1],
                               mem[fl_cmd[9:0] + 10'd2], mem[fl_cmd[9:0] + 10'd3]};
                end
            end
        end else begin
            fl_bits = 0;
        end
    end

    always @(negedge spi_sclk_o) begin
        if (spi_cs_n_o === 1'b0 && fl_bits >= 32 && fl_bits < 64) spi_miso_i = fl_data[63 - fl_bits];
    end

    always @(negedge clk_i) begin
        if (spi_cs_n_o === 1'b1) begin
            csHighRun = csHighRun + 1;
        end else if (csHighRun != 0) begin
            lastGap   = csHighRun;
            csHighRun = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=expired expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we, input logic [31:0] adr);
        wb_cyc_i = cyc;
        wb_stb_i = stb;
        wb_we_i  = we;
        wb_adr_i = adr;
    endtask

    task automatic wbRead(input string tag, input logic [31:0] adr, input bit holdStb,
                          output logic [31:0] data, output int latency);
        bit gotAck = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, adr);
        latency = 0;
        while (!gotAck && latency < 2000) begin
            @(negedge clk_i);
            latency++;
            if (wb_ack_o === 1'b1) gotAck = 1'b1;
        end
        checkOutput({tag, "_ack_seen"}, gotAck, 1);
        data = wb_dat_o;
        if (!holdStb) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic waitRises(input string tag, input int n);
        int guard = 0;
        do begin
            @(negedge clk_i);
            guard++;
        end while (fl_bits < n && guard < 1000);
        checkOutput(tag, (fl_bits >= n), 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cs_n"}, spi_cs_n_o, 1);
        checkOutput({tag, "_sclk"}, spi_sclk_o, 0);
        checkOutput({tag, "_mosi"}, spi_mosi_o, 0);
        checkOutput({tag, "_ack"},  wb_ack_o,   0);
        checkOutput({tag, "_err"},  wb_err_o,   0);
        checkOutput({tag, "_dat"},  wb_dat_o,   32'h0);
    endtask

    initial begin
        logic [31:0] rdData;
        int          rdLat;
        bit          csAllHigh;
        int          ackCount;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0]     = 8'h10; mem[1]     = 8'h32; mem[2]     = 8'h54; mem[3]     = 8'h76;
        mem[4]     = 8'h98; mem[5]     = 8'hBA; mem[6]     = 8'hDC; mem[7]     = 8'hFE;
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        mem[10'h104] = 8'hDE; mem[10'h105] = 8'hAD; mem[10'h106] = 8'hBE; mem[10'h107] = 8'hEF;
        mem[10'h200] = 8'h01; mem[10'h201] = 8'h02; mem[10'h202] = 8'h03; mem[10'h203] = 8'h04;

        wb_dat_i = 32'hCAFE_F00D;
        wb_sel_i = 4'hF;
        rst_n_i  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk_i);
        checkResetOutputs("reset");
        rst_n_i = 1'b1;
        @(negedge clk_i);

        wbRead("rd100", 32'h0000_0100, 1'b0, rdData, rdLat);
        checkOutput("rd100_data", rdData, 32'h4433_2211);
        checkOutput("rd100_latency", rdLat, 260);
        checkOutput("rd100_cmd", lastCmd, 32'h0300_0100);
        @(negedge clk_i);
        checkOutput("rd100_ack_pulse", wb_ack_o, 0);
        checkOutput("rd100_dat_hold", wb_dat_o, 32'h4433_2211);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);

        wbRead("rd103", 32'h0000_0103, 1'b0, rdData, rdLat);
        checkOutput("rd103_cmd", lastCmd, 32'h0300_0100);
        checkOutput("rd103_data", rdData, 32'h4433_2211);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        csAllHigh = spi_cs_n_o;
        @(negedge clk_i);
        checkOutput("wr_err", wb_err_o, 1);
        checkOutput("wr_no_ack", wb_ack_o, 0);
        csAllHigh &= spi_cs_n_o;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        checkOutput("wr_err_pulse", wb_err_o, 0);
        repeat (6) begin
            @(negedge clk_i);
            csAllHigh &= spi_cs_n_o;
        end
        checkOutput("wr_cs_idle", csAllHigh, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);

        wbRead("b2b0", 32'h0000_0000, 1'b1, rdData, rdLat);
        checkOutput("b2b0_data", rdData, 32'h7654_3210);
        wbRead("b2b1", 32'h0000_0004, 1'b0, rdData, rdLat);
        checkOutput("b2b1_data", rdData, 32'hFEDC_BA98);
        checkOutput("b2b1_cmd", lastCmd, 32'h0300_0004);
        checkOutput("b2b_cs_gap", (lastGap >= 2), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0100);
        waitRises("abort_reach_rise20", 20);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        checkOutput("abort_cs_n", spi_cs_n_o, 1);
        checkOutput("abort_sclk", spi_sclk_o, 0);
        ackCount  = 0;
        csAllHigh = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) ackCount++;
            csAllHigh &= spi_cs_n_o;
        end
        checkOutput("abort_no_ack", ackCount, 0);
        checkOutput("abort_cs_stays", csAllHigh, 1);
        wbRead("post_abort", 32'h0000_0104, 1'b0, rdData, rdLat);
        checkOutput("post_abort_data", rdData, 32'hEFBE_ADDE);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0200);
        waitRises("rst_reach_rise40", 40);
        rst_n_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        checkResetOutputs("midrst");
        rst_n_i = 1'b1;
        @(negedge clk_i);
        wbRead("post_rst", 32'h0000_0200, 1'b0, rdData, rdLat);
        checkOutput("post_rst_data", rdData, 32'h0403_0201);
        checkOutput("post_rst_latency", rdLat, 260);
        checkOutput("post_rst_cmd", lastCmd, 32'h0300_0200);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/spi_flash_wb_reader.md
Name: spi_flash_wb_reader

Overview:
Read-only Wishbone classic slave that maps the external SPI boot flash into the SoC address space. Each Wishbone read becomes one SPI READ (0x03) frame. The frame is a 24-bit byte address followed by 32 data bits, and the four bytes are returned as one little-endian word. The block sits between the SoC Wishbone interconnect and the spiflash pads (spi0_cs0/sclk/mosi/miso), alongside the boot ROM.

Parameters:
CLK_DIV, 2, clk_i cycles per SCLK half-period (>=1); one SPI bit = 2*CLK_DIV cycles
FLASH_AW, 24, flash byte-address width driven in the command
READ_OPCODE, 8'h03, SPI read command byte

Ports:
clk_i  in  1  system (Wishbone) clock
rst_n_i  in  1  synchronous active-low reset
wb_adr_i  in  32  byte address; bits [FLASH_AW-1:2] used, [1:0] ignored
wb_dat_i  in  32  write data (ignored)
wb_sel_i  in  4  byte selects (ignored; always full word returned)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  read acknowledge, 1-cycle pulse
wb_err_o  out  1  error acknowledge, 1-cycle pulse
spi_cs_n_o  out  1  flash chip select, active low
spi_sclk_o  out  1  SPI clock, mode 0 (idle low)
spi_mosi_o  out  1  serial data to flash, MSB first
spi_miso_i  in  1  serial data from flash

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): cs_n=1, sclk=0, mosi=0, ack=0, err=0, dat_o=0, state=IDLE. Reset mid-frame aborts the frame; cs_n is high on the next edge and no ack is issued.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> ACK -> IDLE; IDLE -> ERR -> IDLE.
- IDLE:
  - cyc&stb&we: go to ERR. err_o=1 for exactly 1 cycle; no SPI activity.
  - cyc&stb&!we: latch {adr[FLASH_AW-1:2],2'b00}, go to CS_SETUP.
- CS_SETUP: cs_n=0 for CLK_DIV cycles with sclk=0 and mosi = bit 63 of the 64-bit shift word {READ_OPCODE, addr, 32'h0}.
- SHIFT: 64 bits.
  - sclk rises after CLK_DIV cycles low; miso is sampled on that edge.
  - sclk falls after CLK_DIV cycles high; mosi advances to the next bit on the falling edge.
  - Data bits 32..63 are sampled into the receive register MSB first.
  - After the 64th high phase, sclk returns low and the FSM goes to CS_HOLD.
- CS_HOLD: cs_n=1 for 1 cycle.
- ACK: wb_ack_o=1 for 1 cycle. wb_dat_o is byte-swapped from the received stream: first received byte -> [7:0], last -> [31:24]. dat_o holds its value until the next ack.
- Latency: read ack asserts exactly 2 + CLK_DIV + 128*CLK_DIV cycles after the cycle where cyc&stb is first sampled in IDLE (CLK_DIV=2: 260 cycles).
- Master abort: cyc_i low during CS_SETUP or SHIFT -> next cycle cs_n=1 and sclk=0, FSM goes to IDLE, no ack or err.
- cs_n is high for >=2 cycles between back-to-back frames (CS_HOLD + ACK).
- ack and err are never asserted together, and never asserted while cyc_i=0.
- Bit counter is 7 bits; it counts 0..63 and must not wrap inside a frame. The divider counter reloads on every phase change.

Decomposition:
- Shared package spi_flash_pkg: state encoding enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, ACK, ERR), constant FRAME_BITS=64, default opcode 8'h03.
- One sub-module, spi_flash_shifter:
  - contains the clock divider, 64-bit shift-out register, 32-bit shift-in register and bit counter;
  - interface is start/abort/done.
- The Wishbone FSM stays in the top module.

Test Plan:
- Flash bytes at 0x000100 = 11 22 33 44; read wb_adr_i=0x00000100 -> MOSI stream 0x03,0x00,0x01,0x00; wb_ack_o after 260 cycles (CLK_DIV=2); wb_dat_o=0x44332211.
- Read wb_adr_i=0x00000103 -> flash address sent 0x000100 (low bits masked); same data 0x44332211.
- Write cyc=stb=we=1 -> wb_err_o=1 for 1 cycle on the following edge, wb_ack_o=0, spi_cs_n_o stays 1 throughout.
- Back-to-back reads at 0x0 and 0x4 with stb held -> two acks; spi_cs_n_o high >=2 cycles between frames; second data = flash bytes 4..7 swapped.
- Drop wb_cyc_i at SCLK rising edge 20 -> spi_cs_n_o=1 and spi_sclk_o=0 next cycle; no ack; a following read returns correct data.
- Assert rst_n_i=0 for 1 cycle at SCLK edge 40 -> all outputs at reset values next cycle; a subsequent read completes with correct data and latency.
